// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory arbiter: FSM states, access
// size codes and IO-space decode constants.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // IO space is any address with bits [17:16] both set.
  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_MASK      = 32'h0003_0000;

  // Byte count for an LSU size code; the illegal code 3 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto the 8-bit RAM/IO bus,
// sequencing each request as consecutive byte accesses with LSU priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_ADDR,
  parameter int          ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              io_buffer_full,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [2:0]        n_reg, n_next;
  logic              owner_ls_reg, owner_ls_next;
  logic [2:0]        issue_cnt_reg, issue_cnt_next;
  logic [2:0]        recv_cnt_reg, recv_cnt_next;
  logic              data_vld_reg, data_vld_next;
  logic [31:0]       asm_reg, asm_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
  logic [7:0]        mem_dout_reg, mem_dout_next;
  logic              mem_wr_reg, mem_wr_next;
  logic              if_done_reg, if_done_next;
  logic              ls_done_reg, ls_done_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic [31:0]       ls_rdata_reg, ls_rdata_next;
  logic              rdy_prev_reg;

  logic              is_io;
  logic [2:0]        k_inc;
  logic [31:0]       asm_cap;

  assign is_io = ((mem_a_reg & ADDR_W'(IO_MASK)) == ADDR_W'(IO_BASE));
  assign k_inc = issue_cnt_reg + 3'd1;

  // Incoming byte lands in lane recv_cnt; other lanes keep their value.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_cap[8*gi +: 8] = (recv_cnt_reg[1:0] == 2'(gi)) ? mem_din : asm_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    n_next         = n_reg;
    owner_ls_next  = owner_ls_reg;
    issue_cnt_next = issue_cnt_reg;
    recv_cnt_next  = recv_cnt_reg;
    data_vld_next  = data_vld_reg;
    asm_next       = asm_reg;
    wdata_next     = wdata_reg;
    mem_a_next     = mem_a_reg;
    mem_dout_next  = mem_dout_reg;
    mem_wr_next    = mem_wr_reg;
    if_done_next   = 1'b0;
    ls_done_next   = 1'b0;
    if_data_next   = if_data_reg;
    ls_rdata_next  = ls_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        mem_a_next    = '0;
        mem_wr_next   = 1'b0;
        mem_dout_next = 8'h00;
        if (ls_req && !ls_done_reg) begin
          owner_ls_next = 1'b1;
          base_next     = ls_addr;
          n_next        = size_to_n(ls_size);
          wdata_next    = ls_wdata;
          mem_a_next    = ls_addr;
          recv_cnt_next = 3'd0;
          data_vld_next = 1'b0;
          asm_next      = 32'h0;
          if (ls_wr) begin
            state_next     = ST_WRITE;
            issue_cnt_next = 3'd0;
            mem_dout_next  = ls_wdata[7:0];
            mem_wr_next    = 1'b1;
          end else begin
            state_next     = ST_READ;
            issue_cnt_next = 3'd1;
          end
        end else if (if_req && !clear && !if_done_reg) begin
          owner_ls_next  = 1'b0;
          base_next      = if_addr;
          n_next         = 3'd4;
          mem_a_next     = if_addr;
          issue_cnt_next = 3'd1;
          recv_cnt_next  = 3'd0;
          data_vld_next  = 1'b0;
          asm_next       = 32'h0;
          state_next     = ST_READ;
        end
      end

      ST_READ: begin
        if (!owner_ls_reg && clear) begin
          state_next     = ST_IDLE;
          mem_a_next     = '0;
          issue_cnt_next = 3'd0;
          recv_cnt_next  = 3'd0;
          data_vld_next  = 1'b0;
        end else if (!rdy_prev_reg) begin
          // Data that arrived while frozen was dropped; restart from the first missing byte.
          mem_a_next     = base_reg + ADDR_W'(recv_cnt_reg);
          issue_cnt_next = recv_cnt_reg + 3'd1;
          data_vld_next  = 1'b0;
        end else if (data_vld_reg && (recv_cnt_reg + 3'd1 == n_reg)) begin
          if (owner_ls_reg) begin
            ls_done_next  = 1'b1;
            ls_rdata_next = asm_cap;
          end else begin
            if_done_next = 1'b1;
            if_data_next = asm_cap;
          end
          state_next     = ST_IDLE;
          mem_a_next     = '0;
          issue_cnt_next = 3'd0;
          recv_cnt_next  = 3'd0;
          data_vld_next  = 1'b0;
          asm_next       = asm_cap;
        end else begin
          if (data_vld_reg) begin
            asm_next      = asm_cap;
            recv_cnt_next = recv_cnt_reg + 3'd1;
          end
          data_vld_next = 1'b1;
          if (issue_cnt_reg < n_reg) begin
            mem_a_next     = base_reg + ADDR_W'(issue_cnt_reg);
            issue_cnt_next = k_inc;
          end
        end
      end

      ST_WRITE: begin
        if (!(is_io && io_buffer_full)) begin
          if (issue_cnt_reg == n_reg - 3'd1) begin
            ls_done_next   = 1'b1;
            state_next     = ST_IDLE;
            mem_a_next     = '0;
            mem_wr_next    = 1'b0;
            mem_dout_next  = 8'h00;
            issue_cnt_next = 3'd0;
          end else begin
            issue_cnt_next = k_inc;
            mem_a_next     = base_reg + ADDR_W'(k_inc);
            mem_dout_next  = wdata_reg[8*k_inc[1:0] +: 8];
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      n_reg         <= 3'd0;
      owner_ls_reg  <= 1'b0;
      issue_cnt_reg <= 3'd0;
      recv_cnt_reg  <= 3'd0;
      data_vld_reg  <= 1'b0;
      asm_reg       <= 32'h0;
      wdata_reg     <= 32'h0;
      mem_a_reg     <= '0;
      mem_dout_reg  <= 8'h00;
      mem_wr_reg    <= 1'b0;
      if_done_reg   <= 1'b0;
      ls_done_reg   <= 1'b0;
      if_data_reg   <= 32'h0;
      ls_rdata_reg  <= 32'h0;
      rdy_prev_reg  <= 1'b1;
    end else begin
      rdy_prev_reg <= rdy;
      if (rdy) begin
        state_reg     <= state_next;
        base_reg      <= base_next;
        n_reg         <= n_next;
        owner_ls_reg  <= owner_ls_next;
        issue_cnt_reg <= issue_cnt_next;
        recv_cnt_reg  <= recv_cnt_next;
        data_vld_reg  <= data_vld_next;
        asm_reg       <= asm_next;
        wdata_reg     <= wdata_next;
        mem_a_reg     <= mem_a_next;
        mem_dout_reg  <= mem_dout_next;
        mem_wr_reg    <= mem_wr_next;
        if_done_reg   <= if_done_next;
        ls_done_reg   <= ls_done_next;
        if_data_reg   <= if_data_next;
        ls_rdata_reg  <= ls_rdata_next;
      end
    end
  end

  // A held IO write only reaches the bus once the UART buffer has room.
  assign mem_wr   = mem_wr_reg & rdy & ~(is_io & io_buffer_full);
  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  assign if_done  = if_done_reg;
  assign ls_done  = ls_done_reg;
  assign if_data  = if_data_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte RAM model
// whose read data appears one cycle after its address.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ram [0:4095];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  function automatic logic [11:0] ridx(input logic [31:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  // RAM model: preloaded during reset, registered read, write on mem_wr.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
      ram[12'h102] <= 8'h50; ram[12'h103] <= 8'h00;
      ram[12'h104] <= 8'h93; ram[12'h105] <= 8'h00;
      ram[12'h106] <= 8'h10; ram[12'h107] <= 8'h00;
      ram[12'h200] <= 8'h5A; ram[12'h201] <= 8'hA5;
      mem_din <= 8'h00;
    end else begin
      mem_din <= ram[ridx(mem_a)];
      if (mem_wr) ram[ridx(mem_a)] <= mem_dout;
    end
  end

  task automatic idle_inputs();
    io_buffer_full = 1'b0; clear = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a got %h exp %h", mem_a, 32'h0); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
    n_cmp++; if (mem_dout !== 8'h00) begin n_err++; $display("FAIL reset_mem_dout got %h exp 00", mem_dout); end
    n_cmp++; if ({if_done, ls_done} !== 2'b00) begin n_err++; $display("FAIL reset_done got %b exp 00", {if_done, ls_done}); end
    n_cmp++; if (if_data !== 32'h0) begin n_err++; $display("FAIL reset_if_data got %h exp 0", if_data); end
    n_cmp++; if (ls_rdata !== 32'h0) begin n_err++; $display("FAIL reset_ls_rdata got %h exp 0", ls_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (mem_a !== 32'h100 + 32'(c - 1)) begin n_err++; $display("FAIL fetch_addr c=%0d got %h exp %h", c, mem_a, 32'h100 + 32'(c - 1)); end
      end
      n_cmp++; if (if_done !== (c == 6)) begin n_err++; $display("FAIL fetch_done c=%0d got %b exp %b", c, if_done, c == 6); end
      if (c == 6) begin
        n_cmp++; if (if_data !== 32'h00500513) begin n_err++; $display("FAIL fetch_data got %h exp %h", if_data, 32'h00500513); end
        $display("fetch: addr=%h data=%h done_cycle=%0d", if_addr, if_data, c);
      end
      if (c == 7) begin
        n_cmp++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL fetch_idle_bus got a=%h wr=%b exp a=0 wr=0", mem_a, mem_wr); end
      end
      if (if_done) if_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h200;
    for (int c = 0; c <= 12; c++) begin
      #1;
      n_cmp++; if (ls_done !== (c == 4)) begin n_err++; $display("FAIL coll_ls_done c=%0d got %b exp %b", c, ls_done, c == 4); end
      n_cmp++; if (if_done !== (c == 10)) begin n_err++; $display("FAIL coll_if_done c=%0d got %b exp %b", c, if_done, c == 10); end
      if (c == 1 || c == 2) begin
        n_cmp++; if (mem_a !== 32'h200 + 32'(c - 1)) begin n_err++; $display("FAIL coll_ls_addr c=%0d got %h exp %h", c, mem_a, 32'h200 + 32'(c - 1)); end
      end
      if (c == 5) begin
        n_cmp++; if (mem_a !== 32'h100) begin n_err++; $display("FAIL coll_if_addr got %h exp %h", mem_a, 32'h100); end
      end
      if (c == 4) begin
        n_cmp++; if (ls_rdata !== 32'h0000A55A) begin n_err++; $display("FAIL coll_ls_rdata got %h exp %h", ls_rdata, 32'h0000A55A); end
        $display("collision: load addr=%h data=%h done_cycle=%0d", ls_addr, ls_rdata, c);
      end
      if (c == 10) begin
        n_cmp++; if (if_data !== 32'h00500513) begin n_err++; $display("FAIL coll_if_data got %h exp %h", if_data, 32'h00500513); end
        $display("collision: fetch addr=%h data=%h done_cycle=%0d", if_addr, if_data, c);
      end
      if (ls_done) ls_req = 1'b0;
      if (if_done) if_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_io_stall();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    for (int c = 0; c <= 9; c++) begin
      io_buffer_full = (c <= 5);
      #1;
      n_cmp++; if (mem_wr !== (c == 6)) begin n_err++; $display("FAIL io_mem_wr c=%0d got %b exp %b", c, mem_wr, c == 6); end
      n_cmp++; if (ls_done !== (c == 7)) begin n_err++; $display("FAIL io_ls_done c=%0d got %b exp %b", c, ls_done, c == 7); end
      if (c == 6) begin
        n_cmp++; if (mem_dout !== 8'h41 || mem_a !== 32'h0003_0000) begin n_err++; $display("FAIL io_write got a=%h d=%h exp a=00030000 d=41", mem_a, mem_dout); end
        $display("io_stall: store addr=%h data=%h write_cycle=%0d", mem_a, mem_dout, c);
      end
      if (ls_done) ls_req = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++; if (ram[ridx(32'h0003_0000)] !== 8'h41) begin n_err++; $display("FAIL io_ram got %h exp 41", ram[ridx(32'h0003_0000)]); end
    // RAM writes ignore the UART buffer state.
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h10; ls_wdata = 32'h77;
    for (int c = 0; c <= 4; c++) begin
      #1;
      n_cmp++; if (mem_wr !== (c == 1)) begin n_err++; $display("FAIL ram_mem_wr c=%0d got %b exp %b", c, mem_wr, c == 1); end
      n_cmp++; if (ls_done !== (c == 2)) begin n_err++; $display("FAIL ram_ls_done c=%0d got %b exp %b", c, ls_done, c == 2); end
      if (ls_done) begin
        ls_req = 1'b0;
        $display("ram_store: addr=%h data=%h done_cycle=%0d", ls_addr, ls_wdata[7:0], c);
      end
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0;
    n_cmp++; if (ram[ridx(32'h10)] !== 8'h77) begin n_err++; $display("FAIL ram_store_data got %h exp 77", ram[ridx(32'h10)]); end
  endtask

  task automatic test_clear();
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 10; c++) begin
      if (c == 3) clear = 1'b1;
      if (c == 4) begin
        clear = 1'b0; if_req = 1'b0;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h201;
      end
      #1;
      n_cmp++; if (if_done !== 1'b0) begin n_err++; $display("FAIL clear_if_done c=%0d got %b exp 0", c, if_done); end
      n_cmp++; if (ls_done !== (c == 7)) begin n_err++; $display("FAIL clear_ls_done c=%0d got %b exp %b", c, ls_done, c == 7); end
      if (c == 4) begin
        n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL clear_idle got %h exp 0", mem_a); end
      end
      if (c == 5) begin
        n_cmp++; if (mem_a !== 32'h201) begin n_err++; $display("FAIL clear_ls_addr got %h exp 201", mem_a); end
      end
      if (c == 7) begin
        n_cmp++; if (ls_rdata !== 32'h000000A5) begin n_err++; $display("FAIL clear_ls_rdata got %h exp %h", ls_rdata, 32'h000000A5); end
        $display("clear: load after flush addr=%h data=%h done_cycle=%0d", ls_addr, ls_rdata, c);
      end
      if (ls_done) ls_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_wrap();
    logic [31:0] ea [4];
    logic [7:0]  ed [4];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    ed = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'hFFFF_FFFE; ls_wdata = 32'hAABBCCDD;
    for (int c = 0; c <= 7; c++) begin
      #1;
      n_cmp++; if (mem_wr !== (c >= 1 && c <= 4)) begin n_err++; $display("FAIL wrap_mem_wr c=%0d got %b exp %b", c, mem_wr, c >= 1 && c <= 4); end
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (mem_a !== ea[c-1] || mem_dout !== ed[c-1]) begin n_err++; $display("FAIL wrap_byte c=%0d got a=%h d=%h exp a=%h d=%h", c, mem_a, mem_dout, ea[c-1], ed[c-1]); end
      end
      n_cmp++; if (ls_done !== (c == 5)) begin n_err++; $display("FAIL wrap_ls_done c=%0d got %b exp %b", c, ls_done, c == 5); end
      if (ls_done) begin
        ls_req = 1'b0;
        $display("store_wrap: addr=%h data=%h done_cycle=%0d", ls_addr, ls_wdata, c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rdy_freeze();
    int dones = 0;
    if_req = 1'b1; if_addr = 32'h104;
    for (int c = 0; c <= 19; c++) begin
      rdy = !(c == 2 || c == 3);
      #1;
      n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rdy_mem_wr c=%0d got %b exp 0", c, mem_wr); end
      if (if_done) begin
        dones++;
        n_cmp++; if (if_data !== 32'h00100093) begin n_err++; $display("FAIL rdy_if_data got %h exp %h", if_data, 32'h00100093); end
        $display("rdy_freeze: fetch addr=%h data=%h done_cycle=%0d", if_addr, if_data, c);
        if_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL rdy_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) rst = 1'b1;
      if (c == 3) begin rst = 1'b0; ls_req = 1'b0; end
      #1;
      if (c == 1) begin
        n_cmp++; if (mem_a !== 32'h100) begin n_err++; $display("FAIL rmid_addr got %h exp 100", mem_a); end
      end
      if (c == 3) begin
        n_cmp++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h00) begin n_err++; $display("FAIL rmid_bus got a=%h wr=%b d=%h exp zeros", mem_a, mem_wr, mem_dout); end
        n_cmp++; if (ls_rdata !== 32'h0 || if_data !== 32'h0) begin n_err++; $display("FAIL rmid_data got ls=%h if=%h exp zeros", ls_rdata, if_data); end
      end
      n_cmp++; if (ls_done !== 1'b0) begin n_err++; $display("FAIL rmid_ls_done c=%0d got %b exp 0", c, ls_done); end
      @(posedge clk); #1;
    end
    $display("reset_mid: load abandoned by reset");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_io_stall();
    test_clear();
    test_store_wrap();
    test_rdy_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
